line_buffer_3row: RTL and testbench
===================================

// Module: line_buffer_3row
// PURPOSE
//  Upstream feeder for conv_3x3_systolic. Takes a raster-order pixel stream (one pixel/cycle max),
//  stores the two previous image rows, and emits column-aligned 3-pixel vertical slices
//  (top/mid/bottom) on px0/px1/px2 with out_valid driving the conv in_valid.
//  Flags which slices complete a full 3x3 window so downstream can discard edge outputs.
// PARAMETERS
//  DATA_W  8   pixel width (matches conv DATA_W)
//  IMG_W   32  pixels per row (>=3)
//  IMG_H   32  rows per frame (>=3)
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous reset, active low
//  in_valid    in   1        input pixel valid
//  in_sof      in   1        start of frame, qualified by in_valid, marks pixel (0,0)
//  in_pixel    in   DATA_W   input pixel
//  out_valid   out  1        px0..px2 valid this cycle (feeds conv in_valid)
//  px0         out  DATA_W   pixel at (row-2, col): kernel top row
//  px1         out  DATA_W   pixel at (row-1, col): kernel middle row
//  px2         out  DATA_W   pixel at (row,   col): kernel bottom row
//  win_valid   out  1        out_valid && col>=2: slice closes a full 3x3 window
//  out_col     out  $clog2(IMG_W)  column index of emitted slice
//  out_row     out  $clog2(IMG_H)  row index of px2
//  frame_done  out  1        one-cycle pulse with the slice of the last pixel (IMG_H-1, IMG_W-1)
// BEHAVIOUR
//  Reset: all outputs 0, col=0, row=0, state=IDLE. Line RAM contents not reset (never exposed).
//  Storage: two IMG_W x DATA_W line RAMs, lb_top (row-2) and lb_mid (row-1).
//  Per accepted pixel at col c: read lb_top[c], lb_mid[c]; write lb_top[c]<=lb_mid[c],
//    lb_mid[c]<=in_pixel (read-before-write on same address, same cycle).
//  Outputs registered: slice for pixel accepted at cycle N appears at cycle N+1; latency 1.
//  No backpressure: every in_valid pixel is accepted. in_valid low -> counters hold, out_valid=0,
//    win_valid=0, frame_done=0; px*/out_col/out_row hold last values.
//  Counters: col increments per accepted pixel, wraps IMG_W-1 -> 0 and increments row;
//    row wraps IMG_H-1 -> 0 (frame end) and state returns to FILL.
//  FSM:
//   IDLE  : wait for in_valid&&in_sof; that pixel is (0,0); go FILL.
//           in_valid without in_sof in IDLE: pixel dropped, no RAM write, counters held.
//   FILL  : rows 0..1; RAM written, out_valid=0. After last pixel of row 1 -> STREAM.
//   STREAM: rows 2..IMG_H-1; out_valid=1 per accepted pixel. After (IMG_H-1, IMG_W-1):
//           frame_done pulse, counters to 0, state FILL (next frame's in_sof optional).
//  in_sof mid-frame (any state, with in_valid): pixel treated as (0,0); col=row=0, state FILL;
//    old RAM data overwritten before it is ever emitted; no frame_done for aborted frame.
//  in_sof on the exact expected (0,0) pixel: no-op beyond normal wrap.
//  Async reset mid-frame: everything to reset values immediately; next frame requires in_sof.
//  Width rules: pure data movement, no arithmetic on pixels; counters use $clog2 widths.
// TESTING
//  T1 IMG_W=4,IMG_H=4, pixel=row*16+col, continuous valid from sof -> first out_valid one cycle
//     after pixel (2,0): px0=0x00,px1=0x10,px2=0x20; 8 out_valid total; win_valid on cols 2,3 only.
//  T2 Same frame with in_valid low every other cycle -> identical slice sequence, out_valid only
//     one cycle after each accepted pixel, counters stable during gaps.
//  T3 Two back-to-back frames (second sof on next cycle after last pixel) -> frame_done pulses
//     exactly once per frame, with slice px0=0x13,px1=0x23,px2=0x33; frame 2 output equals frame 1.
//  T4 in_sof asserted at pixel (2,1) of frame 1 -> no further out_valid until new row 2;
//     then slices reflect only new-frame data; no frame_done for aborted frame.
//  T5 rst_n pulsed low mid row 3 -> outputs 0 asynchronously; pixels without sof dropped;
//     after sof, normal T1 sequence.
//  T6 Chained with conv_3x3_systolic, all-ones kernel, pixel=1 -> every win_valid window
//     produces conv out_pixel=9 at conv latency.

Source files
------------

// File: rtl/line_buffer_3row_if.sv
// Pixel-stream bus between a raster source and the 3-row line buffer.
// The source drives the input pixel stream.
// The line buffer drives the vertical 3-pixel slices and their position tags.
interface line_buffer_3row_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_pixel;
  logic              out_valid;
  logic [DATA_W-1:0] px0;
  logic [DATA_W-1:0] px1;
  logic [DATA_W-1:0] px2;
  logic              win_valid;
  logic [CW-1:0]     out_col;
  logic [RW-1:0]     out_row;
  logic              frame_done;

  // Upstream pixel source.
  modport master (
    output in_valid, in_sof, in_pixel,
    input  out_valid, px0, px1, px2, win_valid, out_col, out_row, frame_done
  );

  // Line buffer side.
  modport slave (
    input  in_valid, in_sof, in_pixel,
    output out_valid, px0, px1, px2, win_valid, out_col, out_row, frame_done
  );
endinterface

// File: rtl/line_buffer_3row.sv
// Three-row line buffer that feeds a 3x3 convolution.
// It keeps the two previous image rows in line RAMs and emits column-aligned
// vertical slices (top/mid/bottom) one cycle after each accepted pixel.
// There is no backpressure: every valid pixel is taken. The only exception
// is a pixel that arrives without sof before the first frame start, which is
// dropped.
module line_buffer_3row #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  line_buffer_3row_if.slave  lb
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FILL = RW'(1);

  // Line RAMs: row-2 and row-1 relative to the incoming pixel.
  logic [DATA_W-1:0] r_lb_top [IMG_W];
  logic [DATA_W-1:0] r_lb_mid [IMG_W];

  logic [1:0]        r_state;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;

  logic              r_out_valid;
  logic              r_win_valid;
  logic              r_frame_done;
  logic [DATA_W-1:0] r_px0;
  logic [DATA_W-1:0] r_px1;
  logic [DATA_W-1:0] r_px2;
  logic [CW-1:0]     r_out_col;
  logic [RW-1:0]     r_out_row;

  logic              w_sof;
  logic              w_acc;
  logic [1:0]        w_state;
  logic [CW-1:0]     w_col;
  logic [RW-1:0]     w_row;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_emit;
  logic [1:0]        w_state_nxt;
  logic [CW-1:0]     w_col_nxt;
  logic [RW-1:0]     w_row_nxt;

  // A qualified sof restarts the frame from any state.
  // The pixel that carries it is always treated as position (0,0).
  assign w_sof   = lb.in_valid && lb.in_sof;
  assign w_acc   = lb.in_valid && (r_state != S_IDLE || lb.in_sof);
  assign w_state = w_sof ? S_FILL : r_state;
  assign w_col   = w_sof ? '0 : r_col;
  assign w_row   = w_sof ? '0 : r_row;

  assign w_col_last = (w_col == COL_LAST);
  assign w_row_last = (w_row == ROW_LAST);
  assign w_emit     = w_acc && (w_state == S_STREAM);

  // Next position and state for an accepted pixel.
  // Rows 0..1 only fill the RAMs; the end of row 1 starts streaming.
  always_comb begin
    w_state_nxt = w_state;
    w_col_nxt   = w_col + CW'(1);
    w_row_nxt   = w_row;
    if (w_col_last) begin
      w_col_nxt = '0;
      if (w_row_last) begin
        w_row_nxt   = '0;
        w_state_nxt = S_FILL;
      end else begin
        w_row_nxt = w_row + RW'(1);
        if (w_row == ROW_FILL) w_state_nxt = S_STREAM;
      end
    end
  end

  // Position counters and FSM; they hold when no pixel is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else if (w_acc) begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // Shift the column down one row: mid moves to top, the new pixel goes to mid.
  // Stale data left after a frame abort is overwritten before it is ever read out.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb_top[w_col] <= r_lb_mid[w_col];
      r_lb_mid[w_col] <= lb.in_pixel;
    end
  end

  // Registered slice output.
  // Data and position tags only change on an emitted slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_px0        <= '0;
      r_px1        <= '0;
      r_px2        <= '0;
      r_out_col    <= '0;
      r_out_row    <= '0;
    end else begin
      r_out_valid  <= w_emit;
      r_win_valid  <= w_emit && (w_col >= CW'(2));
      r_frame_done <= w_emit && w_col_last && w_row_last;
      if (w_emit) begin
        r_px0     <= r_lb_top[w_col];
        r_px1     <= r_lb_mid[w_col];
        r_px2     <= lb.in_pixel;
        r_out_col <= w_col;
        r_out_row <= w_row;
      end
    end
  end

  assign lb.out_valid  = r_out_valid;
  assign lb.win_valid  = r_win_valid;
  assign lb.frame_done = r_frame_done;
  assign lb.px0        = r_px0;
  assign lb.px1        = r_px1;
  assign lb.px2        = r_px2;
  assign lb.out_col    = r_out_col;
  assign lb.out_row    = r_out_row;
endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed bench for line_buffer_3row on a 4x4 image.
// Pixel value is base + row*16 + col. Expected slices are built from that formula.
module tb_line_buffer_3row;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   npass = 0;
  int   nchk  = 0;
  int   ov_cnt, wv_cnt, fd_cnt;
  logic [31:0] exp_col, exp_row, exp_px2;

  always #5 clk = ~clk;

  line_buffer_3row_if #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) bus ();

  line_buffer_3row #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lb    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one input for one clock; the outputs after it show that pixel's slice.
  task automatic cyc(input logic v, input logic sof, input logic [7:0] pix);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_pixel = pix;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    if (bus.out_valid)  ov_cnt++;
    if (bus.win_valid)  wv_cnt++;
    if (bus.frame_done) fd_cnt++;
  endtask

  // Check that the outputs are idle and the held slice fields are unchanged.
  task automatic chk_idle(input string tag);
    chk({tag, ".ov"},  32'(bus.out_valid), 0);
    chk({tag, ".col"}, 32'(bus.out_col),   exp_col);
    chk({tag, ".px2"}, 32'(bus.px2),       exp_px2);
  endtask

  // Send one whole frame, optionally with sof and idle gaps, and check every slice.
  task automatic send_frame(input logic [7:0] base, input logic use_sof, input logic gap);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        cyc(1'b1, use_sof && r == 0 && c == 0, base + 8'(r * 16 + c));
        if (r >= 2) begin
          exp_col = c; exp_row = r; exp_px2 = base + r * 16 + c;
          chk("ov",  32'(bus.out_valid),  1);
          chk("px0", 32'(bus.px0),        base + (r - 2) * 16 + c);
          chk("px1", 32'(bus.px1),        base + (r - 1) * 16 + c);
          chk("px2", 32'(bus.px2),        exp_px2);
          chk("win", 32'(bus.win_valid),  (c >= 2) ? 1 : 0);
          chk("col", 32'(bus.out_col),    exp_col);
          chk("row", 32'(bus.out_row),    exp_row);
          chk("fd",  32'(bus.frame_done), (r == 3 && c == 3) ? 1 : 0);
        end else begin
          chk_idle("fill");
        end
        if (gap) begin
          cyc(1'b0, 1'b0, 8'hEE);
          chk_idle("gap");
          chk("gap.win", 32'(bus.win_valid), 0);
        end
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pixel = '0;
    exp_col = 0; exp_row = 0; exp_px2 = 0;
    ov_cnt = 0; wv_cnt = 0; fd_cnt = 0;
    #12 rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    chk("rst.ov",  32'(bus.out_valid),  0);
    chk("rst.px0", 32'(bus.px0),        0);
    chk("rst.row", 32'(bus.out_row),    0);
    chk("rst.fd",  32'(bus.frame_done), 0);

    // A pixel before any sof is dropped; the T1 frame must still line up.
    cyc(1'b1, 1'b0, 8'h77);
    chk("idle.ov", 32'(bus.out_valid), 0);

    // T1: continuous frame.
    ov_cnt = 0; wv_cnt = 0; fd_cnt = 0;
    send_frame(8'h00, 1'b1, 1'b0);
    chk("t1.ovcnt", 32'(ov_cnt), 8);
    chk("t1.wvcnt", 32'(wv_cnt), 4);
    chk("t1.fdcnt", 32'(fd_cnt), 1);

    // T2: gaps between pixels; sof on the expected (0,0) changes nothing.
    ov_cnt = 0; fd_cnt = 0;
    send_frame(8'h00, 1'b1, 1'b1);
    chk("t2.ovcnt", 32'(ov_cnt), 8);
    chk("t2.fdcnt", 32'(fd_cnt), 1);

    // T3: back-to-back frames; the second one has no sof at all.
    fd_cnt = 0;
    send_frame(8'h00, 1'b1, 1'b0);
    chk("t3.px0", 32'(bus.px0), 32'h13);
    chk("t3.px1", 32'(bus.px1), 32'h23);
    send_frame(8'h00, 1'b0, 1'b0);
    chk("t3.fdcnt", 32'(fd_cnt), 2);
    cyc(1'b0, 1'b0, 8'h00);
    chk("t3.fdoff", 32'(bus.frame_done), 0);

    // T4: abort at (2,1) with a new sof; new frame data is based at 0x80.
    fd_cnt = 0; ov_cnt = 0;
    for (int i = 0; i < 9; i++) cyc(1'b1, i == 0, 8'(i / 4 * 16 + i % 4));
    chk("t4.px2", 32'(bus.px2), 32'h20);
    exp_col = 0; exp_row = 2; exp_px2 = 32'h20;
    send_frame(8'h80, 1'b1, 1'b0);
    chk("t4.ovcnt", 32'(ov_cnt), 9);
    chk("t4.fdcnt", 32'(fd_cnt), 1);

    // T5: asynchronous reset in the middle of row 3.
    for (int i = 0; i < 14; i++) cyc(1'b1, i == 0, 8'(i / 4 * 16 + i % 4));
    chk("t5.pre", 32'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5.ov",  32'(bus.out_valid), 0);
    chk("t5.px1", 32'(bus.px1),       0);
    chk("t5.col", 32'(bus.out_col),   0);
    chk("t5.row", 32'(bus.out_row),   0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_col = 0; exp_row = 0; exp_px2 = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 8'h55);
      chk_idle("t5.drop");
    end
    fd_cnt = 0;
    send_frame(8'h00, 1'b1, 1'b0);
    chk("t5.fdcnt", 32'(fd_cnt), 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
